switch_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one switch jump table between several microsequencer requesters. Each requester presents a switch-table base (`jadr`) and case offset. The arbiter grants one request at a time, drives the table's lookup port for one cycle, and registers the returned case address. It then returns that address to the winning requester with a valid/ready handshake. It sits between the microsequencer cores and the single switch-table instance.

---
 rtl/switch_arb_if.sv | 35 +++
 rtl/switch_arb.sv | 119 +++++++++++
 tb/tb_switch_arb.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_arb_if.sv
// switch_arb_if: request/response and switch-table lookup bundle for switch_arb.
// master is the arbiter side, slave is the requester/table side.
interface switch_arb_if #(
  parameter int NUM_REQ         = 4,
  parameter int ADR_BUS_WIDTH   = 8,
  parameter int SWITCH_MEM_BITS = 8
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ*ADR_BUS_WIDTH-1:0]   req_jadr;
  logic [NUM_REQ*SWITCH_MEM_BITS-1:0] req_offset;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [NUM_REQ-1:0]                 rsp_ready;
  logic [ADR_BUS_WIDTH-1:0]           rsp_adr;
  logic                               tbl_ready;
  logic                               tbl_active;
  logic [ADR_BUS_WIDTH-1:0]           tbl_jadr;
  logic [SWITCH_MEM_BITS-1:0]         tbl_offset;
  logic [ADR_BUS_WIDTH-1:0]           tbl_adr;
  logic                               busy;

  modport master (
    input  req_valid, req_jadr, req_offset,
    input  rsp_ready, tbl_ready, tbl_adr,
    output req_ready, rsp_valid, rsp_adr,
    output tbl_active, tbl_jadr, tbl_offset, busy
  );

  modport slave (
    output req_valid, req_jadr, req_offset,
    output rsp_ready, tbl_ready, tbl_adr,
    input  req_ready, rsp_valid, rsp_adr,
    input  tbl_active, tbl_jadr, tbl_offset, busy
  );
endinterface

// File: rtl/switch_arb.sv
// switch_arb: shares one switch jump table among NUM_REQ microsequencers.
// Define SWITCH_ARB_RR_EN for round-robin; otherwise lowest index wins.
module switch_arb #(
  parameter int NUM_REQ         = 4,
  parameter int ADR_BUS_WIDTH   = 8,
  parameter int SWITCH_MEM_BITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  switch_arb_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP
  } state_t;

  state_t                     r_state;
  state_t                     w_nxt;
  logic [IW-1:0]              r_gnt;
  logic [ADR_BUS_WIDTH-1:0]   r_jadr;
  logic [SWITCH_MEM_BITS-1:0] r_off;
  logic [ADR_BUS_WIDTH-1:0]   r_adr;
  logic [IW-1:0]              w_win;
  logic                       w_any;
  logic                       w_grant;
  logic [NUM_REQ-1:0]         w_rdy;
  logic [NUM_REQ-1:0]         w_rsp;

`ifdef SWITCH_ARB_RR_EN
  logic [IW-1:0] r_ptr;

  // Rotating search starting at the pointer.
  always_comb begin
    int idx;
    idx   = 0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_any && bus.req_valid[IW'(idx)]) begin
        w_any = 1'b1;
        w_win = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    end
  end
`else
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && bus.req_valid[IW'(k)]) begin
        w_any = 1'b1;
        w_win = IW'(k);
      end
    end
  end
`endif

  assign w_grant = (r_state == S_IDLE) && !rst &&
                   bus.tbl_ready && w_any;

  always_comb begin
    w_nxt = r_state;
    w_rdy = '0;
    w_rsp = '0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_nxt        = S_LOOKUP;
          w_rdy[w_win] = 1'b1;
        end
      end
      S_LOOKUP: w_nxt = S_RESP;
      S_RESP: begin
        w_rsp[r_gnt] = 1'b1;
        if (bus.rsp_ready[r_gnt]) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_jadr  <= '0;
      r_off   <= '0;
      r_adr   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_grant) begin
        r_gnt  <= w_win;
        r_jadr <= bus.req_jadr[w_win*ADR_BUS_WIDTH +: ADR_BUS_WIDTH];
        r_off  <= bus.req_offset[w_win*SWITCH_MEM_BITS +: SWITCH_MEM_BITS];
      end
      if (r_state == S_LOOKUP) r_adr <= bus.tbl_adr;
    end
  end

  assign bus.req_ready  = w_rdy;
  assign bus.rsp_valid  = w_rsp;
  assign bus.rsp_adr    = r_adr;
  assign bus.tbl_active = (r_state == S_LOOKUP);
  assign bus.tbl_jadr   = r_jadr;
  assign bus.tbl_offset = r_off;
  assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_switch_arb.sv
// tb_switch_arb: directed vector table, hand sequences and a random
// run against a transaction-level model of the shared switch table.
module tb_switch_arb;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_arb_if #(.NUM_REQ(N), .ADR_BUS_WIDTH(AW),
                  .SWITCH_MEM_BITS(OW)) ifc ();

  switch_arb #(.NUM_REQ(N), .ADR_BUS_WIDTH(AW),
               .SWITCH_MEM_BITS(OW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.master)
  );

  int n_vec = 0;
  int n_err = 0;

  bit         use_tv;
  logic [7:0] tv_ta;

  function automatic logic [7:0] tfun(logic [7:0] j, logic [7:0] o);
    logic [7:0] m;
    m = o * 8'd5;
    return (j + m) ^ 8'hA5;
  endfunction

  always_comb begin
    if (use_tv) ifc.tbl_adr = tv_ta;
    else if (ifc.tbl_active) ifc.tbl_adr = tfun(ifc.tbl_jadr, ifc.tbl_offset);
    else ifc.tbl_adr = 8'h00;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int oh2i(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    logic         r;
    logic [N-1:0] rv;
    logic [31:0]  jadr;
    logic [31:0]  off;
    logic [N-1:0] rr;
    logic         tr;
    logic [7:0]   ta;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rsp;
    logic [7:0]   e_adr;
    logic         e_act;
    logic [7:0]   e_j;
    logic [7:0]   e_o;
    logic         e_busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    bit r, logic [3:0] rv, int rq, logic [7:0] j, logic [7:0] o,
    logic [3:0] rr, bit tr, logic [7:0] ta,
    logic [3:0] erdy, logic [3:0] ersp, logic [7:0] eadr,
    bit eact, logic [7:0] ej, logic [7:0] eo, bit eb);
    vec_t v;
    v.r = r; v.rv = rv; v.rr = rr; v.tr = tr; v.ta = ta;
    v.jadr = '0; v.off = '0;
    v.jadr[rq*8 +: 8] = j;
    v.off[rq*8 +: 8]  = o;
    v.e_rdy = erdy; v.e_rsp = ersp; v.e_adr = eadr;
    v.e_act = eact; v.e_j = ej; v.e_o = eo; v.e_busy = eb;
    return v;
  endfunction

  task automatic clear_in();
    ifc.req_valid  = '0;
    ifc.req_jadr   = '0;
    ifc.req_offset = '0;
    ifc.rsp_ready  = '0;
    ifc.tbl_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // model state for the random run
  int         p;
  bit         infl;
  int         age;
  int         g;
  logic [7:0] ej, eo, eadr;
  bit         pend[N];
  logic [7:0] rj[N], ro[N];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         got[6];
    int         fexp[6];
    int         ng;
    int         win;
    logic [7:0] bexp;
    logic [N-1:0] e_rdy, e_rsp;

    rst    = 1'b1;
    use_tv = 1'b1;
    tv_ta  = 8'h00;
    clear_in();
    repeat (2) @(negedge clk);

    // single lookup
    tv.push_back(mk(1,4'b0000,0,8'h00,8'h00,4'b0000,1,8'h00, 4'b0000,4'b0000,8'h00,0,8'h00,8'h00,0));
    tv.push_back(mk(0,4'b0010,1,8'h02,8'h05,4'b0000,1,8'h00, 4'b0010,4'b0000,8'h00,0,8'h00,8'h00,0));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0000,1,8'h3C, 4'b0000,4'b0000,8'h00,1,8'h02,8'h05,1));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0000,1,8'h00, 4'b0000,4'b0010,8'h3C,0,8'h02,8'h05,1));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0010,1,8'h00, 4'b0000,4'b0010,8'h3C,0,8'h02,8'h05,1));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0000,1,8'h00, 4'b0000,4'b0000,8'h3C,0,8'h02,8'h05,0));
    // table not ready for 5 cycles
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0,4'b0100,2,8'h11,8'h22,4'b0000,0,8'h00, 4'b0000,4'b0000,8'h3C,0,8'h02,8'h05,0));
    tv.push_back(mk(0,4'b0100,2,8'h11,8'h22,4'b0000,1,8'h00, 4'b0100,4'b0000,8'h3C,0,8'h02,8'h05,0));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0000,0,8'h5A, 4'b0000,4'b0000,8'h3C,1,8'h11,8'h22,1));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b1011,0,8'h00, 4'b0000,4'b0100,8'h5A,0,8'h11,8'h22,1));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0100,0,8'h00, 4'b0000,4'b0100,8'h5A,0,8'h11,8'h22,1));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0000,1,8'h00, 4'b0000,4'b0000,8'h5A,0,8'h11,8'h22,0));
    // reset during lookup
    tv.push_back(mk(0,4'b0001,0,8'h40,8'h41,4'b0000,1,8'h00, 4'b0001,4'b0000,8'h5A,0,8'h11,8'h22,0));
    tv.push_back(mk(1,4'b0000,0,8'h00,8'h00,4'b0000,1,8'h77, 4'b0000,4'b0000,8'h5A,1,8'h40,8'h41,1));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0000,1,8'h00, 4'b0000,4'b0000,8'h00,0,8'h00,8'h00,0));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b1111,1,8'h00, 4'b0000,4'b0000,8'h00,0,8'h00,8'h00,0));
    // pointer is back at 0 after reset
    tv.push_back(mk(0,4'b1111,0,8'h33,8'h44,4'b0000,1,8'h00, 4'b0001,4'b0000,8'h00,0,8'h00,8'h00,0));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0000,1,8'h99, 4'b0000,4'b0000,8'h00,1,8'h33,8'h44,1));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0001,1,8'h00, 4'b0000,4'b0001,8'h99,0,8'h33,8'h44,1));
    tv.push_back(mk(0,4'b0000,0,8'h00,8'h00,4'b0000,1,8'h00, 4'b0000,4'b0000,8'h99,0,8'h33,8'h44,0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst            = tv[i].r;
      ifc.req_valid  = tv[i].rv;
      ifc.req_jadr   = tv[i].jadr;
      ifc.req_offset = tv[i].off;
      ifc.rsp_ready  = tv[i].rr;
      ifc.tbl_ready  = tv[i].tr;
      tv_ta          = tv[i].ta;
      #1;
      chk($sformatf("tv%0d req_ready", i), 32'(ifc.req_ready), 32'(tv[i].e_rdy));
      chk($sformatf("tv%0d rsp_valid", i), 32'(ifc.rsp_valid), 32'(tv[i].e_rsp));
      chk($sformatf("tv%0d rsp_adr", i), 32'(ifc.rsp_adr), 32'(tv[i].e_adr));
      chk($sformatf("tv%0d tbl_active", i), 32'(ifc.tbl_active), 32'(tv[i].e_act));
      chk($sformatf("tv%0d tbl_jadr", i), 32'(ifc.tbl_jadr), 32'(tv[i].e_j));
      chk($sformatf("tv%0d tbl_offset", i), 32'(ifc.tbl_offset), 32'(tv[i].e_o));
      chk($sformatf("tv%0d busy", i), 32'(ifc.busy), 32'(tv[i].e_busy));
    end
    use_tv = 1'b0;

    // fairness: all requesters always valid, responses always consumed
`ifdef SWITCH_ARB_RR_EN
    fexp = '{0, 1, 2, 3, 0, 1};
`else
    fexp = '{0, 0, 0, 0, 0, 0};
`endif
    do_reset();
    ifc.req_valid = 4'b1111;
    ifc.rsp_ready = 4'b1111;
    ifc.tbl_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ifc.req_jadr[i*8 +: 8]   = 8'(i * 16 + 1);
      ifc.req_offset[i*8 +: 8] = 8'(i + 7);
    end
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      #1;
      if (|ifc.req_ready) begin
        chk("fair onehot", 32'($countones(ifc.req_ready)), 32'd1);
        got[ng] = oh2i(ifc.req_ready);
        ng++;
      end
      @(negedge clk);
    end
    chk("fair grant count", 32'(ng), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < ng) chk($sformatf("fair grant%0d", k), 32'(got[k]), 32'(fexp[k]));

    // response backpressure with another requester waiting
    do_reset();
    ifc.tbl_ready = 1'b1;
    ifc.req_valid = 4'b1000;
    ifc.req_jadr[3*8 +: 8]   = 8'h21;
    ifc.req_offset[3*8 +: 8] = 8'h13;
    bexp = tfun(8'h21, 8'h13);
    ng = 0;
    for (int c = 0; c < 5 && ng == 0; c++) begin
      #1;
      if (ifc.req_ready == 4'b1000) ng = 1;
      else @(negedge clk);
    end
    chk("bp grant seen", 32'(ng), 32'd1);
    @(negedge clk);
    ifc.req_valid = 4'b0001;
    ifc.req_jadr[7:0]   = 8'h55;
    ifc.req_offset[7:0] = 8'h66;
    #1;
    chk("bp lookup active", 32'(ifc.tbl_active), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d rsp_valid", c), 32'(ifc.rsp_valid), 32'(4'b1000));
      chk($sformatf("bp%0d rsp_adr", c), 32'(ifc.rsp_adr), 32'(bexp));
      chk($sformatf("bp%0d req_ready", c), 32'(ifc.req_ready), 32'd0);
    end
    @(negedge clk);
    ifc.rsp_ready = 4'b1000;
    #1;
    chk("bp consume rsp_valid", 32'(ifc.rsp_valid), 32'(4'b1000));
    @(negedge clk);
    ifc.rsp_ready = 4'b0000;
    #1;
    chk("bp after rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("bp next grant", 32'(ifc.req_ready), 32'(4'b0001));

    // random traffic against the transaction model
    do_reset();
    p = 0;
    infl = 1'b0;
    age = 0;
    g = 0;
    ej = '0; eo = '0; eadr = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; rj[i] = '0; ro[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          rj[i]   = 8'($urandom);
          ro[i]   = 8'($urandom);
        end
        ifc.req_valid[i]         = pend[i];
        ifc.req_jadr[i*8 +: 8]   = pend[i] ? rj[i] : 8'($urandom);
        ifc.req_offset[i*8 +: 8] = pend[i] ? ro[i] : 8'($urandom);
      end
      ifc.rsp_ready = 4'($urandom);
      ifc.tbl_ready = ($urandom_range(0, 4) != 0);
      #1;
      e_rdy = '0;
      e_rsp = '0;
      win   = -1;
      if (!infl) begin
        if (ifc.tbl_ready) begin
          for (int k = 0; k < N; k++) begin
`ifdef SWITCH_ARB_RR_EN
            if (win < 0 && pend[(p + k) % N]) win = (p + k) % N;
`else
            if (win < 0 && pend[k]) win = k;
`endif
          end
        end
        if (win >= 0) e_rdy[win] = 1'b1;
      end else if (age >= 2) begin
        e_rsp[g] = 1'b1;
      end
      chk($sformatf("rnd%0d req_ready", c), 32'(ifc.req_ready), 32'(e_rdy));
      chk($sformatf("rnd%0d rsp_valid", c), 32'(ifc.rsp_valid), 32'(e_rsp));
      chk($sformatf("rnd%0d tbl_active", c), 32'(ifc.tbl_active), 32'(infl && age == 1));
      chk($sformatf("rnd%0d busy", c), 32'(ifc.busy), 32'(infl));
      if (infl) begin
        chk($sformatf("rnd%0d tbl_jadr", c), 32'(ifc.tbl_jadr), 32'(ej));
        chk($sformatf("rnd%0d tbl_offset", c), 32'(ifc.tbl_offset), 32'(eo));
      end
      if (infl && age >= 2)
        chk($sformatf("rnd%0d rsp_adr", c), 32'(ifc.rsp_adr), 32'(eadr));
      if (win >= 0) begin
        infl = 1'b1;
        age  = 1;
        g    = win;
        ej   = rj[win];
        eo   = ro[win];
        eadr = tfun(ej, eo);
        pend[win] = 1'b0;
        p = (win + 1) % N;
      end else if (infl && age == 1) begin
        age = 2;
      end else if (infl && ifc.rsp_ready[g]) begin
        infl = 1'b0;
      end
    end

    @(negedge clk);
    clear_in();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
